adder_xxbit_multicycle: RTL and testbench
=========================================

Name: adder_xxbit_multicycle

Overview:
Multi-cycle wide adder controller. It sequences one narrow adder_xxbit_serial instance (SLICE_WIDTH bits) across a DATA_WIDTH-bit operand pair, one slice per clock, with the carry held in a register between slices. This trades latency for area in wide datapaths. It has a valid/ready handshake on both the operand side and the result side.

Parameters:
DATA_WIDTH, 32, operand and result width; must be an integer multiple of SLICE_WIDTH
SLICE_WIDTH, 8, width of the internal adder_xxbit_serial instance
- Derived: NUM_SLICES = DATA_WIDTH / SLICE_WIDTH; slice counter width = $clog2(NUM_SLICES), minimum 1.

Ports:
i_clk  input  1  clock; all state updates on the rising edge
i_rst_n  input  1  asynchronous active-low reset
i_valid  input  1  operand request valid
o_ready  output  1  block can accept operands
i_num_a  input  DATA_WIDTH  operand a
i_num_b  input  DATA_WIDTH  operand b
i_cry  input  1  carry into bit 0
o_valid  output  1  result valid
i_ready  input  1  consumer accepts result
o_res  output  DATA_WIDTH  sum
o_cry  output  1  carry out of bit DATA_WIDTH-1
o_busy  output  1  high in CALC or DONE

Behaviour:
- Clocking and reset: one clock (i_clk). Reset is asynchronous and active-low (i_rst_n).
- Reset values:
  - state = IDLE, slice counter = 0, carry register = 0.
  - Operand registers = 0, o_res = 0, o_cry = 0, o_valid = 0, o_busy = 0.
  - o_ready = 1 once reset is released.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - o_ready = 1.
  - Acceptance is i_valid && o_ready at a rising edge.
  - On acceptance: latch i_num_a, i_num_b and i_cry into registers; clear the counter; go to CALC.
  - Input values are don't-care after the accepting edge.
- CALC:
  - o_ready = 0.
  - Each cycle, the slice adder takes bits [k*SLICE_WIDTH +: SLICE_WIDTH] of the latched a and b, plus the carry register.
  - At the edge: write the slice sum into o_res at the same position, store the slice carry in the carry register, increment k.
  - When k == NUM_SLICES-1 at the edge: also load o_cry with the final carry and go to DONE.
- DONE:
  - o_valid = 1; o_res and o_cry stay stable.
  - On i_valid-independent i_ready == 1 at the edge: go to IDLE, o_valid drops the next cycle.
  - o_valid must not drop without i_ready; backpressure may last indefinitely.
- Latency: exactly NUM_SLICES edges from the accepting edge to o_valid = 1.
  - NUM_SLICES = 1 is legal, giving a latency of 1.
- Throughput: one operation per NUM_SLICES+2 cycles minimum (accept, NUM_SLICES CALC edges, handshake). There is no accept-in-DONE bypass.
- o_res and o_cry hold their last values after the result handshake until the next acceptance begins overwriting slices.
  - Partial o_res during CALC is don't-care to consumers.
- i_valid in CALC/DONE is ignored (o_ready = 0). The requester holds it.
- Arithmetic: modulo 2^DATA_WIDTH. The result must equal {o_cry, o_res} = a + b + i_cry exactly.
- Reset asserted mid-operation: immediate return to the reset values; the in-flight operation is discarded, with no partial o_valid.
- o_busy = (state != IDLE).

Optional Feature:
- Macro: ADDER_XXBIT_MULTICYCLE_SUB_EN.
- Defined:
  - Extra port i_sub (input, 1), latched at acceptance.
  - When i_sub = 1, the latched b is bitwise inverted and the initial carry is forced to 1; i_cry is ignored. Result o_res = a - b mod 2^DATA_WIDTH.
  - o_cry = 1 means no borrow (a >= b unsigned).
  - When i_sub = 0, behaviour is identical to addition.
- Undefined: no i_sub port; addition only; no inverter logic.

Test Plan (DATA_WIDTH=32, SLICE_WIDTH=8 unless noted):
1. Carry ripple across all slices: a=0xFFFFFFFF, b=0x00000001, cry=0 -> o_res=0x00000000, o_cry=1; o_valid rises exactly 4 edges after acceptance; o_ready=0 during CALC.
2. Backpressure: a=0x12345678, b=0x11111111, cry=1; i_ready held 0 for 10 cycles -> o_valid stays 1 and o_res=0x2345678A, o_cry=0 stable throughout; one cycle after i_ready=1, o_valid=0 and o_ready=1.
3. Reset mid-operation: assert i_rst_n=0 asynchronously after 2 CALC edges -> o_valid=0, o_busy=0, o_res=0, o_cry=0 immediately; after release, a=5, b=7 -> o_res=12.
4. Back-to-back operations: i_valid held 1 with new operands, i_ready=1 -> results 0x00000003 (1+2) then 0x80000000 (0x7FFFFFFF+1, o_cry=0); accept edges spaced 6 cycles apart; random regression of 1000 operations vs. a reference model.
5. Degenerate slicing: DATA_WIDTH=SLICE_WIDTH=8, a=0xF0, b=0x20, cry=0 -> o_res=0x10, o_cry=1, latency 1.
6. With ADDER_XXBIT_MULTICYCLE_SUB_EN: a=3, b=5, i_sub=1 -> o_res=0xFFFFFFFE, o_cry=0; a=5, b=3 -> o_res=2, o_cry=1.

Source files
------------

// File: rtl/adder_xxbit_multicycle_if.sv
// -----------------------------------------------------------------------------
// adder_xxbit_multicycle_if
// Operand-request and result-response bundle for adder_xxbit_multicycle.
//   i_valid / o_ready          operand handshake (requester -> adder)
//   i_num_a, i_num_b, i_cry    operands and carry into bit 0
//   i_sub                      subtract select (only with ADDER_XXBIT_MULTICYCLE_SUB_EN)
//   o_valid / i_ready          result handshake (adder -> consumer)
//   o_res, o_cry               sum and carry out of the top bit
//   o_busy                     operation in flight or result pending
// Modports: slave = the adder, master = requester/consumer side.
// -----------------------------------------------------------------------------
interface adder_xxbit_multicycle_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  i_valid;
    logic                  o_ready;
    logic [DATA_WIDTH-1:0] i_num_a;
    logic [DATA_WIDTH-1:0] i_num_b;
    logic                  i_cry;
`ifdef ADDER_XXBIT_MULTICYCLE_SUB_EN
    logic                  i_sub;
`endif
    logic                  o_valid;
    logic                  i_ready;
    logic [DATA_WIDTH-1:0] o_res;
    logic                  o_cry;
    logic                  o_busy;

    modport slave (
        input  i_valid, i_num_a, i_num_b, i_cry, i_ready,
`ifdef ADDER_XXBIT_MULTICYCLE_SUB_EN
        input  i_sub,
`endif
        output o_ready, o_valid, o_res, o_cry, o_busy
    );

    modport master (
        output i_valid, i_num_a, i_num_b, i_cry, i_ready,
`ifdef ADDER_XXBIT_MULTICYCLE_SUB_EN
        output i_sub,
`endif
        input  o_ready, o_valid, o_res, o_cry, o_busy
    );
endinterface

// File: rtl/adder_xxbit_multicycle.sv
// -----------------------------------------------------------------------------
// adder_xxbit_multicycle
// Wide adder built from one SLICE_WIDTH-bit adder reused across the operand,
// one slice per clock, with the slice carry held in a register in between.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      adder_xxbit_multicycle_if.slave (operand/result handshakes)
// Latency is DATA_WIDTH/SLICE_WIDTH edges from acceptance to o_valid.
// Optional feature macro: ADDER_XXBIT_MULTICYCLE_SUB_EN adds i_sub, which turns
// the operation into a - b (o_cry = 1 means no borrow).
// -----------------------------------------------------------------------------

// Narrow slice adder: {cry_out, sum} = num_a + num_b + cry_in.
module adder_xxbit_serial #(
    parameter int SLICE_WIDTH = 8
) (
    input  logic [SLICE_WIDTH-1:0] num_a,
    input  logic [SLICE_WIDTH-1:0] num_b,
    input  logic                   cry_in,
    output logic [SLICE_WIDTH-1:0] sum,
    output logic                   cry_out
);
    assign {cry_out, sum} = {1'b0, num_a} + {1'b0, num_b} + {{SLICE_WIDTH{1'b0}}, cry_in};
endmodule

module adder_xxbit_multicycle #(
    parameter int DATA_WIDTH  = 32,
    parameter int SLICE_WIDTH = 8
) (
    input logic                      i_clk,
    input logic                      i_rst_n,
    adder_xxbit_multicycle_if.slave  bus
);
    localparam int NUM_SLICES = DATA_WIDTH / SLICE_WIDTH;
    localparam int CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_SLICES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [DATA_WIDTH-1:0]   num_a;
    logic [DATA_WIDTH-1:0]   num_b;
    logic [DATA_WIDTH-1:0]   res;
    logic                    carry;
    logic                    cry;
    logic [CNT_W-1:0]        cnt;

    logic                    accept;
    logic                    last;
    logic [31:0]             shift_amt;
    logic [SLICE_WIDTH-1:0]  slice_a;
    logic [SLICE_WIDTH-1:0]  slice_b;
    logic [SLICE_WIDTH-1:0]  slice_sum;
    logic                    slice_cry;
    logic [DATA_WIDTH-1:0]   slice_mask;
    logic [DATA_WIDTH-1:0]   res_next;
    logic [DATA_WIDTH-1:0]   b_load;
    logic                    carry_load;

    assign accept = (state == IDLE) && bus.i_valid;
    assign last   = (cnt == LAST);

    // Subtraction is a + ~b + 1: invert b once at acceptance so the slice
    // loop never needs to know which operation is running.
`ifdef ADDER_XXBIT_MULTICYCLE_SUB_EN
    assign b_load     = bus.i_sub ? ~bus.i_num_b : bus.i_num_b;
    assign carry_load = bus.i_sub ? 1'b1 : bus.i_cry;
`else
    assign b_load     = bus.i_num_b;
    assign carry_load = bus.i_cry;
`endif

    // Slice k lives at bit offset k*SLICE_WIDTH; select by shifting so the
    // same logic works for any slice count, including a single slice.
    assign shift_amt = 32'(cnt) * 32'(SLICE_WIDTH);
    assign slice_a   = SLICE_WIDTH'(num_a >> shift_amt);
    assign slice_b   = SLICE_WIDTH'(num_b >> shift_amt);

    adder_xxbit_serial #(
        .SLICE_WIDTH (SLICE_WIDTH)
    ) u_slice (
        .num_a   (slice_a),
        .num_b   (slice_b),
        .cry_in  (carry),
        .sum     (slice_sum),
        .cry_out (slice_cry)
    );

    assign slice_mask = DATA_WIDTH'({SLICE_WIDTH{1'b1}}) << shift_amt;
    assign res_next   = (res & ~slice_mask) | (DATA_WIDTH'(slice_sum) << shift_amt);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)      state_next = CALC;
            CALC:    if (last)        state_next = DONE;
            DONE:    if (bus.i_ready) state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    // Operand latch, slice sequencing and result assembly
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            num_a <= '0;
            num_b <= '0;
            res   <= '0;
            carry <= 1'b0;
            cry   <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        num_a <= bus.i_num_a;
                        num_b <= b_load;
                        carry <= carry_load;
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    res   <= res_next;
                    carry <= slice_cry;
                    cnt   <= cnt + CNT_W'(1);
                    if (last) begin
                        cry <= slice_cry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_ready = (state == IDLE);
    assign bus.o_valid = (state == DONE);
    assign bus.o_busy  = (state != IDLE);
    assign bus.o_res   = res;
    assign bus.o_cry   = cry;
endmodule

// File: tb/tb_adder_xxbit_multicycle.sv
// -----------------------------------------------------------------------------
// tb_adder_xxbit_multicycle
// Self-checking bench: a 32/8 instance for the main scenarios and an 8/8
// instance for single-slice operation. Expected results come from plain
// wide arithmetic in ref_add.
// -----------------------------------------------------------------------------
module tb_adder_xxbit_multicycle;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    adder_xxbit_multicycle_if #(.DATA_WIDTH(32)) bus ();
    adder_xxbit_multicycle_if #(.DATA_WIDTH(8))  bus8 ();

    adder_xxbit_multicycle #(.DATA_WIDTH(32), .SLICE_WIDTH(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    adder_xxbit_multicycle #(.DATA_WIDTH(8), .SLICE_WIDTH(8)) dut8 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus8)
    );

    // {carry, sum} of a + b + c, or {no-borrow, a - b} when subtracting.
    function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic c, input logic s);
        logic [32:0] r;
        if (s) begin
            r[31:0] = a - b;
            r[32]   = (a >= b);
        end else begin
            r = 33'(a) + 33'(b) + 33'(c);
        end
        return r;
    endfunction

    // Present one operation, wait for the accepting edge, then count edges
    // until o_valid. Leaves the result pending (i_ready low).
    task automatic start_wait(input logic [31:0] a, input logic [31:0] b, input logic c,
                              output int lat, output bit tout, output bit rdy_bad);
        bus.i_num_a = a;
        bus.i_num_b = b;
        bus.i_cry   = c;
        bus.i_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        bus.i_num_a = $urandom;
        bus.i_num_b = $urandom;
        bus.i_cry   = 1'($urandom);
        lat = 0;
        tout = 1'b0;
        rdy_bad = bus.o_ready;
        while (1) begin
            @(posedge clk); #1;
            lat++;
            if (bus.o_valid) break;
            if (bus.o_ready) rdy_bad = 1'b1;
            if (lat >= 40) begin
                tout = 1'b1;
                break;
            end
        end
    endtask

    task automatic handshake();
        bus.i_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got valid=%b busy=%b exp 0 0", bus.o_valid, bus.o_busy);
        end
        checks++;
        if (bus.o_res !== 32'h0 || bus.o_cry !== 1'b0) begin
            errors++;
            $display("FAIL reset_data got res=%h cry=%b exp 0 0", bus.o_res, bus.o_cry);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.o_ready !== 1'b1 || bus8.o_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b/%b exp 1/1", bus.o_ready, bus8.o_ready);
        end
    endtask

    task automatic test_carry_ripple();
        int lat; bit tout; bit rdy_bad;
        start_wait(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat, tout, rdy_bad);
        checks++;
        if (tout || lat != 4) begin
            errors++;
            $display("FAIL ripple_latency got %0d (timeout=%b) exp 4", lat, tout);
        end
        checks++;
        if (rdy_bad) begin
            errors++;
            $display("FAIL ripple_ready_in_calc got 1 exp 0");
        end
        checks++;
        if (bus.o_res !== 32'h0 || bus.o_cry !== 1'b1) begin
            errors++;
            $display("FAIL ripple_result got %h/%b exp 00000000/1", bus.o_res, bus.o_cry);
        end
        handshake();
    endtask

    task automatic test_backpressure();
        int lat; bit tout; bit rdy_bad;
        start_wait(32'h1234_5678, 32'h1111_1111, 1'b1, lat, tout, rdy_bad);
        checks++;
        if (tout || bus.o_res !== 32'h2345_678A || bus.o_cry !== 1'b0) begin
            errors++;
            $display("FAIL bp_result got %h/%b exp 2345678a/0", bus.o_res, bus.o_cry);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.o_valid !== 1'b1 || bus.o_res !== 32'h2345_678A || bus.o_cry !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got v=%b %h/%b exp 1 2345678a/0",
                         i, bus.o_valid, bus.o_res, bus.o_cry);
            end
        end
        handshake();
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got valid=%b ready=%b exp 0 1", bus.o_valid, bus.o_ready);
        end
    endtask

    task automatic test_reset_mid();
        int lat; bit tout; bit rdy_bad;
        bus.i_num_a = 32'hFFFF_FFFF;
        bus.i_num_b = 32'hFFFF_FFFF;
        bus.i_cry   = 1'b1;
        bus.i_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.o_busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_busy_before got %b exp 1", bus.o_busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_res !== 32'h0 || bus.o_cry !== 1'b0) begin
            errors++;
            $display("FAIL midrst_clear got v=%b busy=%b res=%h cry=%b exp 0 0 0 0",
                     bus.o_valid, bus.o_busy, bus.o_res, bus.o_cry);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_wait(32'd5, 32'd7, 1'b0, lat, tout, rdy_bad);
        checks++;
        if (tout || bus.o_res !== 32'd12 || bus.o_cry !== 1'b0) begin
            errors++;
            $display("FAIL midrst_after got %h/%b exp 0000000c/0", bus.o_res, bus.o_cry);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        logic [31:0] op_a [2];
        logic [31:0] op_b [2];
        logic [31:0] exp_r [2];
        logic [31:0] got_r [2];
        logic        got_c [2];
        int          acc_cyc [2];
        int n_acc = 0;
        int n_res = 0;
        bit acc;
        op_a[0] = 32'd1;          op_b[0] = 32'd2;  exp_r[0] = 32'h0000_0003;
        op_a[1] = 32'h7FFF_FFFF;  op_b[1] = 32'd1;  exp_r[1] = 32'h8000_0000;
        bus.i_num_a = op_a[0];
        bus.i_num_b = op_b[0];
        bus.i_cry   = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_ready = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            acc = bus.i_valid && bus.o_ready;
            if (bus.o_valid && n_res < 2) begin
                got_r[n_res] = bus.o_res;
                got_c[n_res] = bus.o_cry;
                n_res++;
            end
            @(posedge clk); #1;
            if (acc && n_acc < 2) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                if (n_acc < 2) begin
                    bus.i_num_a = op_a[n_acc];
                    bus.i_num_b = op_b[n_acc];
                end else begin
                    bus.i_valid = 1'b0;
                end
            end
        end
        bus.i_ready = 1'b0;
        checks++;
        if (n_acc != 2 || n_res != 2) begin
            errors++;
            $display("FAIL b2b_counts got acc=%0d res=%0d exp 2 2", n_acc, n_res);
        end else begin
            checks++;
            if (acc_cyc[1] - acc_cyc[0] != 6) begin
                errors++;
                $display("FAIL b2b_spacing got %0d exp 6", acc_cyc[1] - acc_cyc[0]);
            end
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (got_r[i] !== exp_r[i] || got_c[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_result%0d got %h/%b exp %h/0", i, got_r[i], got_c[i], exp_r[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        int lat; bit tout; bit rdy_bad;
        logic [31:0] a, b;
        logic c, s;
        logic [32:0] exp;
        for (int n = 0; n < 1000; n++) begin
            a = (n % 10 == 0) ? 32'hFFFF_FFFF : $urandom;
            b = (n % 10 == 1) ? 32'hFFFF_FFFF : ((n % 10 == 2) ? 32'h0 : $urandom);
            c = 1'($urandom);
            s = 1'b0;
`ifdef ADDER_XXBIT_MULTICYCLE_SUB_EN
            s = 1'($urandom);
            bus.i_sub = s;
`endif
            exp = ref_add(a, b, c, s);
            start_wait(a, b, c, lat, tout, rdy_bad);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
            checks++;
            if (tout || lat != 4 || rdy_bad || {bus.o_cry, bus.o_res} !== exp) begin
                errors++;
                $display("FAIL random%0d a=%h b=%h c=%b s=%b got %b/%h lat=%0d exp %b/%h lat=4",
                         n, a, b, c, s, bus.o_cry, bus.o_res, lat, exp[32], exp[31:0]);
            end
            handshake();
        end
`ifdef ADDER_XXBIT_MULTICYCLE_SUB_EN
        bus.i_sub = 1'b0;
`endif
    endtask

    task automatic test_single_slice();
        int lat = 0;
        bit tout = 1'b0;
        bus8.i_num_a = 8'hF0;
        bus8.i_num_b = 8'h20;
        bus8.i_cry   = 1'b0;
        bus8.i_valid = 1'b1;
        @(posedge clk); #1;
        bus8.i_valid = 1'b0;
        bus8.i_num_a = 8'($urandom);
        while (1) begin
            @(posedge clk); #1;
            lat++;
            if (bus8.o_valid) break;
            if (lat >= 20) begin
                tout = 1'b1;
                break;
            end
        end
        checks++;
        if (tout || lat != 1) begin
            errors++;
            $display("FAIL single_latency got %0d (timeout=%b) exp 1", lat, tout);
        end
        checks++;
        if (bus8.o_res !== 8'h10 || bus8.o_cry !== 1'b1) begin
            errors++;
            $display("FAIL single_result got %h/%b exp 10/1", bus8.o_res, bus8.o_cry);
        end
        bus8.i_ready = 1'b1;
        @(posedge clk); #1;
        bus8.i_ready = 1'b0;
        checks++;
        if (bus8.o_valid !== 1'b0 || bus8.o_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_release got valid=%b ready=%b exp 0 1", bus8.o_valid, bus8.o_ready);
        end
    endtask

`ifdef ADDER_XXBIT_MULTICYCLE_SUB_EN
    task automatic test_sub();
        int lat; bit tout; bit rdy_bad;
        bus.i_sub = 1'b1;
        start_wait(32'd3, 32'd5, 1'b1, lat, tout, rdy_bad);
        checks++;
        if (tout || bus.o_res !== 32'hFFFF_FFFE || bus.o_cry !== 1'b0) begin
            errors++;
            $display("FAIL sub_borrow got %h/%b exp fffffffe/0", bus.o_res, bus.o_cry);
        end
        handshake();
        bus.i_sub = 1'b1;
        start_wait(32'd5, 32'd3, 1'b0, lat, tout, rdy_bad);
        checks++;
        if (tout || bus.o_res !== 32'd2 || bus.o_cry !== 1'b1) begin
            errors++;
            $display("FAIL sub_noborrow got %h/%b exp 00000002/1", bus.o_res, bus.o_cry);
        end
        handshake();
        bus.i_sub = 1'b0;
    endtask
`endif

    initial begin
        bus.i_valid  = 1'b0;
        bus.i_ready  = 1'b0;
        bus.i_num_a  = '0;
        bus.i_num_b  = '0;
        bus.i_cry    = 1'b0;
        bus8.i_valid = 1'b0;
        bus8.i_ready = 1'b0;
        bus8.i_num_a = '0;
        bus8.i_num_b = '0;
        bus8.i_cry   = 1'b0;
`ifdef ADDER_XXBIT_MULTICYCLE_SUB_EN
        bus.i_sub    = 1'b0;
        bus8.i_sub   = 1'b0;
`endif
        test_reset();
        test_carry_ripple();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_single_slice();
`ifdef ADDER_XXBIT_MULTICYCLE_SUB_EN
        test_sub();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
